// File: rtl/cache_request_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | cache_request_unit: CPU-side data cache front end. Turns byte loads/stores  |
// | into word cache accesses (read-modify-write for sub-word stores).           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cache_request_unit #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 27
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_LEN+1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_LEN-1:0]   c_addr,
  output logic [DATA_LEN-1:0]   c_wdata,
  input  logic [DATA_LEN-1:0]   c_rdata,
  output logic                  c_read_or_write,
  output logic                  c_req,
  input  logic                  c_finish
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_RD   = 3'd2,
    S_GAP  = 3'd3,
    S_WR   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_store;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_LEN+1:0]   r_addr;
  logic [DATA_LEN-1:0]   r_wdata;
  logic [DATA_LEN-1:0]   r_rdata;

  logic                  w_accept;
  logic                  w_misaligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_LEN-1:0]   w_load_data;
  logic [DATA_LEN-1:0]   w_merged;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_misaligned = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Little-endian lane selection within the returned word
  assign w_byte = c_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = c_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = c_rdata;
    case (r_size)
      2'b00:   w_load_data = {{(DATA_LEN-8){w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_load_data = {{(DATA_LEN-16){w_half[15] & ~r_unsigned}}, w_half};
      default: w_load_data = c_rdata;
    endcase
  end

  always_comb begin
    w_merged = c_rdata;
    if (r_size == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)                         w_next = S_ERR;
          else if (!req_store || req_size != 2'b10) w_next = S_RD;
          else                                      w_next = S_WR;
        end
      end
      S_ERR:  w_next = S_IDLE;
      S_RD:   if (c_finish) w_next = r_store ? S_GAP : S_RESP;
      S_GAP:  w_next = S_WR;
      S_WR:   if (c_finish) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_store    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store    <= req_store;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_rdata    <= '0;
      end
      // The merged word replaces the store data so WR always sends r_wdata
      if ((r_state == S_RD) && c_finish) begin
        if (r_store) r_wdata <= w_merged;
        else         r_rdata <= w_load_data;
      end
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = (r_state == S_RESP) || (r_state == S_ERR);
  assign resp_err        = (r_state == S_ERR);
  assign resp_rdata      = (r_state == S_RESP) ? r_rdata : '0;
  assign c_req           = (r_state == S_RD) || (r_state == S_WR);
  assign c_read_or_write = (r_state != S_WR);
  assign c_addr          = r_addr[ADDR_LEN+1:2];
  assign c_wdata         = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_request_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_cache_request_unit: random and directed stimulus, cache responder model, |
// | scoreboard of expected responses and expected cache accesses.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cache_request_unit;
  localparam int DL = 32;
  localparam int AL = 27;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]    req_size;
  logic [AL+1:0] req_addr;
  logic [DL-1:0] req_wdata;
  logic          resp_valid, resp_err;
  logic [DL-1:0] resp_rdata;
  logic [AL-1:0] c_addr;
  logic [DL-1:0] c_wdata, c_rdata;
  logic          c_read_or_write, c_req, c_finish;

  always #5 clk = ~clk;

  cache_request_unit #(.DATA_LEN(DL), .ADDR_LEN(AL)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata),
    .c_read_or_write(c_read_or_write), .c_req(c_req), .c_finish(c_finish)
  );

  typedef struct {logic [31:0] rdata; logic err;} resp_t;
  typedef struct {logic rd; logic [AL-1:0] addr; logic [31:0] wdata; int gap;} acc_t;

  resp_t       exp_resp_q[$];
  acc_t        exp_acc_q[$];
  int          resp_cycs[$];
  logic [31:0] ref_mem [256];
  logic [31:0] cache_mem [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fix_lat = -1;
  int          accept_cyc = 0;
  int          creq_cycles = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference behaviour: byte-level arithmetic on a word-array memory
  function automatic void model(input bit st, input bit [1:0] sz, input bit uns,
                                input logic [28:0] a, input logic [31:0] wd);
    int nbytes = 1 << sz;
    int sh = 8 * int'(a[1:0]);
    logic [31:0] word, mask, val;
    resp_t r;
    acc_t  c;
    r.rdata = '0;
    r.err   = 1'b0;
    if (sz == 2'd3 || (int'(a[1:0]) % nbytes) != 0) begin
      r.err = 1'b1;
      exp_resp_q.push_back(r);
      return;
    end
    word    = ref_mem[a[9:2]];
    mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    c.addr  = a[28:2];
    c.wdata = '0;
    c.gap   = -1;
    if (!st) begin
      val = (word >> sh) & mask;
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
      c.rd = 1'b1;
      exp_acc_q.push_back(c);
      r.rdata = val;
    end else begin
      if (nbytes < 4) begin
        c.rd = 1'b1;
        exp_acc_q.push_back(c);
        word  = (word & ~(mask << sh)) | ((wd & mask) << sh);
        c.gap = 1;
      end else begin
        word = wd;
      end
      c.rd    = 1'b0;
      c.wdata = word;
      exp_acc_q.push_back(c);
      ref_mem[a[9:2]] = word;
    end
    exp_resp_q.push_back(r);
  endfunction

  // Response monitor
  initial begin
    logic prev_valid = 1'b0;
    resp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (resp_valid) begin
          check("resp_single_pulse", {63'd0, prev_valid}, 64'd0);
          resp_cycs.push_back(cyc);
          last_rdata = resp_rdata;
          last_err   = resp_err;
          if (exp_resp_q.size() == 0) begin
            fail_now("unexpected_resp");
          end else begin
            e = exp_resp_q.pop_front();
            check("resp", {31'd0, resp_rdata, resp_err}, {31'd0, e.rdata, e.err});
          end
        end
        prev_valid = resp_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // Cache controller model
  initial begin
    bit active = 0;
    int cnt = 0;
    int low_cnt = 0;
    int rise_gap = 0;
    acc_t a;
    c_finish = 1'b0;
    c_rdata  = '0;
    forever begin
      @(negedge clk);
      c_finish = 1'b0;
      if (!rstn) begin
        active  = 0;
        low_cnt = 0;
      end else if (c_req) begin
        creq_cycles++;
        if (!active) begin
          active   = 1;
          rise_gap = low_cnt;
          cnt      = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          active  = 0;
          low_cnt = 0;
          if (exp_acc_q.size() == 0) begin
            fail_now("unexpected_cache_access");
          end else begin
            a = exp_acc_q.pop_front();
            check("cache_op", {36'd0, c_read_or_write, c_addr}, {36'd0, a.rd, a.addr});
            if (!a.rd) check("cache_wdata", {32'd0, c_wdata}, {32'd0, a.wdata});
            if (a.gap >= 0) check("rmw_gap", 64'(rise_gap), 64'(a.gap));
          end
          if (c_read_or_write) c_rdata = cache_mem[c_addr[7:0]];
          else                 cache_mem[c_addr[7:0]] = c_wdata;
          c_finish = 1'b1;
        end else begin
          cnt--;
        end
      end else begin
        low_cnt++;
        // Stray finish pulses while no access is outstanding must be ignored
        if ($urandom_range(0, 7) == 0) begin
          c_finish = 1'b1;
          c_rdata  = $urandom;
        end
      end
    end
  end

  task automatic issue(input bit st, input bit [1:0] sz, input bit uns,
                       input logic [28:0] a, input logic [31:0] wd);
    bit done = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        model(st, sz, uns, a, wd);
        accept_cyc = cyc;
        done = 1;
        @(posedge clk);
      end
    end
    if (!done) fail_now("accept_timeout");
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 400 && (exp_resp_q.size() != 0 || exp_acc_q.size() != 0); i++)
      @(negedge clk);
    if (exp_resp_q.size() != 0 || exp_acc_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_resp_q.delete();
      exp_acc_q.delete();
    end
  endtask

  task automatic preset(input int w, input logic [31:0] v);
    ref_mem[w]   = v;
    cache_mem[w] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int          base, c0, idx;
    logic [31:0] saved;
    bit [1:0]    sz;
    logic [28:0] a;
    for (int i = 0; i < 256; i++) preset(i, $urandom);
    rstn = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, req_ready, resp_valid, resp_err, resp_rdata, c_req, c_read_or_write},
          {27'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1});
    check("reset_cache_bus", {5'd0, c_addr, c_wdata}, 64'd0);
    rstn = 1'b1;

    // LW with fixed 3-cycle finish latency
    fix_lat = 3;
    preset(8'h40, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 29'h100, 32'h0);
    drain();
    check("lw_0x100", {32'd0, last_rdata}, {32'd0, 32'hDEADBEEF});
    fix_lat = -1;

    preset(8'h40, 32'h80FF0011);
    issue(0, 2'b00, 0, 29'h103, 32'h0); drain();
    check("lb_signed", {32'd0, last_rdata}, {32'd0, 32'hFFFFFF80});
    issue(0, 2'b00, 1, 29'h103, 32'h0); drain();
    check("lbu", {32'd0, last_rdata}, {32'd0, 32'h00000080});
    issue(0, 2'b01, 1, 29'h102, 32'h0); drain();
    check("lhu", {32'd0, last_rdata}, {32'd0, 32'h000080FF});

    preset(8'h40, 32'h11223344);
    base = resp_cycs.size();
    issue(1, 2'b00, 0, 29'h101, 32'h0000005A); drain();
    check("sb_merge", {32'd0, cache_mem[8'h40]}, {32'd0, 32'h11225A44});
    check("sb_one_resp", 64'(resp_cycs.size() - base), 64'd1);

    issue(1, 2'b10, 0, 29'h200, 32'hCAFEF00D); drain();
    check("sw_word", {32'd0, cache_mem[8'h80]}, {32'd0, 32'hCAFEF00D});

    c0 = creq_cycles;
    issue(0, 2'b01, 0, 29'h101, 32'h0); drain();
    check("lh_misaligned_err", {63'd0, last_err}, 64'd1);
    check("err_no_cache_req", 64'(creq_cycles - c0), 64'd0);

    // Reset while the write phase is outstanding
    saved = ref_mem[8'hC0];
    fix_lat = 8;
    issue(1, 2'b10, 0, 29'h300, 32'h12345678);
    for (int i = 0; i < 50 && !(c_req && !c_read_or_write); i++) @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_reset", {61'd0, c_req, req_ready, resp_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
    rstn = 1'b1;
    exp_resp_q.delete();
    exp_acc_q.delete();
    ref_mem[8'hC0] = saved;
    fix_lat = -1;
    repeat (5) @(negedge clk);
    preset(8'h40, 32'hA5A5_0F0F);
    issue(0, 2'b10, 0, 29'h100, 32'h0); drain();
    check("lw_after_reset", {32'd0, last_rdata}, {32'd0, 32'hA5A5_0F0F});

    // Back-to-back loads with req_valid held high
    base = resp_cycs.size();
    issue(0, 2'b10, 0, 29'h100, 32'h0);
    issue(0, 2'b10, 0, 29'h104, 32'h0);
    idx = accept_cyc;
    drain();
    if (resp_cycs.size() > base) check("back_to_back", 64'(idx), 64'(resp_cycs[base] + 1));
    else fail_now("back_to_back_no_resp");

    // Randomized mix
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 29'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
    end
    drain();
    for (int i = 0; i < 256; i++) begin
      if (cache_mem[i] !== ref_mem[i]) check("final_mem", {32'd0, cache_mem[i]}, {32'd0, ref_mem[i]});
    end
    check("final_mem_word", {32'd0, cache_mem[8'h80]}, {32'd0, ref_mem[8'h80]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
